ctrl_seq: RTL and testbench
===========================

# ctrl_seq

Eight-phase instruction sequencer that drives the datapath around the accumulator ALU: it fetches an instruction, decodes the 3-bit opcode, steers memory/PC/IR/accumulator enables, and consumes the ALU `zero` flag for conditional skip. It sits between the instruction register and the ALU/memory/PC, producing all per-phase control strobes. It also provides sticky halt with resume, and a retired-instruction counter.

## Interface
- `CNT_WIDTH`, default 16: width of the retired-instruction counter.
- `clk`  input  1  single clock; all state updates on rising edge.
- `rst_n`  input  1  reset, asynchronous, active-low.
- `opcode`  input  3  current IR opcode (HLT=0, SKZ=1, ADD=2, AND=3, XOR=4, LDA=5, STO=6, JMP=7).
- `zero`  input  1  ALU zero flag (accumulator == 0).
- `resume`  input  1  one-cycle pulse; leaves HALTED.
- `sel`  output  1  address mux: 1 = PC, 0 = IR operand.
- `rd`  output  1  memory read enable.
- `ld_ir`  output  1  load instruction register.
- `inc_pc`  output  1  increment PC.
- `ld_pc`  output  1  load PC from operand.
- `ld_ac`  output  1  load accumulator from ALU `out`.
- `wr`  output  1  memory write strobe.
- `data_e`  output  1  drive accumulator onto data bus.
- `halt`  output  1  halt indication.
- `phase`  output  3  current phase index (0–7), for debug.
- `retired`  output  CNT_WIDTH  count of completed instructions.

## Operation
- State register, 9 states: INST_ADDR(0), INST_FETCH(1), INST_LOAD(2), IDLE(3), OP_ADDR(4), OP_FETCH(5), ALU_OP(6), STORE(7), HALTED (reports `phase`=4).
- Normal progression: 0→1→…→7→0, one state per cycle, unconditional.
- ALUOP ≡ opcode ∈ {ADD, AND, XOR, LDA}.
- Output decode is combinational from registered state and current `opcode`/`zero`:
  - `sel` = 1 in states 0–3.
  - `rd` = 1 in 1–3; 1 in 5–7 if ALUOP.
  - `ld_ir` = 1 in 2–3.
  - `halt` = 1 in OP_ADDR if HLT; 1 throughout HALTED.
  - `inc_pc` = 1 in OP_ADDR (always, including HLT); in ALU_OP if SKZ && `zero`; in STORE if JMP.
  - `ld_pc` = 1 in ALU_OP and STORE if JMP.
  - `ld_ac` = 1 in STORE if ALUOP.
  - `wr` = 1 in STORE if STO.
  - `data_e` = 1 in ALU_OP and STORE if STO.
  - All outputs are 0 wherever not listed.
- HLT: in OP_ADDR, if HLT then next state is HALTED, not OP_FETCH. In HALTED all strobes are 0 except `halt`. `resume`=1 → next state INST_ADDR; otherwise hold.
- `resume` outside HALTED is ignored.
- `retired` increments by 1 on every STORE→INST_ADDR transition and on every OP_ADDR→HALTED transition. It wraps modulo 2^CNT_WIDTH.
- `opcode` and `zero` are sampled combinationally. An opcode change mid-instruction affects decode immediately; the IR owner must hold it stable from state 4 through 7.
- An illegal state encoding recovers to INST_ADDR on the next edge.

## Timing
- Reset (async assert, any cycle, including mid-STORE): state=INST_ADDR, `retired`=0.
  - Outputs after reset: `sel`=1, all other strobes 0, `phase`=0.
  - `wr` deasserts combinationally with reset assertion.
- First rising edge after `rst_n` deasserts moves to INST_FETCH.
- One instruction takes exactly 8 cycles; HLT takes 5 cycles to reach HALTED.
- Resume latency: `resume` high at edge N → INST_ADDR in cycle N+1.
- `zero` is consulted only in ALU_OP; its value in other states is don't-care.

## Structure
- Shared package `risc_pkg` holds:
  - `opcode_e` (3-bit enum above), shared with the ALU.
  - `state_e`.
  - The ALUOP membership function.
- Single module; no sub-module. The next-state logic and output decode are two separate combinational processes, plus one registered process for state/counter.

## Test plan
- Reset mid-STORE with opcode=STO: `wr` drops immediately; after release `sel`=1, `phase`=0, `retired`=0.
- opcode=ADD for 8 cycles: `rd` high in phases 1,2,3,5,6,7; `ld_ir` in 2–3; `inc_pc` only in 4; `ld_ac` only in 7; `retired` 0→1.
- opcode=SKZ: with `zero`=1, `inc_pc` high in phases 4 and 6; with `zero`=0, high only in 4.
- opcode=STO: `data_e` high in 6–7, `wr` high only in 7, `rd` never high in 5–7. opcode=JMP: `ld_pc` high in 6–7, `inc_pc` high in 4 and 7.
- opcode=HLT: `halt` high in phase 4, then HALTED.
  - Holds 10 cycles with all strobes 0 and `retired` incremented once.
  - `resume` pulse → `phase`=0 next cycle.
  - `resume` during normal run has no effect.
- 2^CNT_WIDTH instructions with CNT_WIDTH=4 (16 ADDs): `retired` wraps 15→0.

Source files
------------

// File: rtl/risc_pkg.sv
// Shared definitions for the accumulator CPU: opcodes, sequencer states and
// the opcode-class helper used by the control decode.
package risc_pkg;

   typedef enum logic [2:0] {
      OpHlt = 3'd0,
      OpSkz = 3'd1,
      OpAdd = 3'd2,
      OpAnd = 3'd3,
      OpXor = 3'd4,
      OpLda = 3'd5,
      OpSto = 3'd6,
      OpJmp = 3'd7
   } opcode_e;

   // Low three bits of the eight run states equal the phase index.
   typedef enum logic [3:0] {
      StInstAddr  = 4'd0,
      StInstFetch = 4'd1,
      StInstLoad  = 4'd2,
      StIdle      = 4'd3,
      StOpAddr    = 4'd4,
      StOpFetch   = 4'd5,
      StAluOp     = 4'd6,
      StStore     = 4'd7,
      StHalted    = 4'd8
   } state_e;

   // Opcodes that read a memory operand and write the accumulator.
   function automatic logic is_aluop(opcode_e op);
      return (op == OpAdd) || (op == OpAnd) || (op == OpXor) || (op == OpLda);
   endfunction

endpackage

// File: rtl/ctrl_seq.sv
// Eight-phase instruction sequencer: steers memory, PC, IR and accumulator
// strobes, supports sticky halt with resume, and counts retired instructions.
module ctrl_seq
   import risc_pkg::*;
#(
   parameter int unsigned CNT_WIDTH = 16
) (
   input  logic                 clk,
   input  logic                 rst_n,
   input  opcode_e              opcode,
   input  logic                 zero,
   input  logic                 resume,
   output logic                 sel,
   output logic                 rd,
   output logic                 ld_ir,
   output logic                 inc_pc,
   output logic                 ld_pc,
   output logic                 ld_ac,
   output logic                 wr,
   output logic                 data_e,
   output logic                 halt,
   output logic [2:0]           phase,
   output logic [CNT_WIDTH-1:0] retired
);

   state_e               state_q, state_d;
   logic [CNT_WIDTH-1:0] retired_q, retired_d;
   logic                 aluop;

   assign aluop   = is_aluop(opcode);
   assign retired = retired_q;

   // Next-state and retire-count logic.
   always_comb begin
      state_d   = StInstAddr;
      retired_d = retired_q;
      case (state_q)
         StInstAddr:  state_d = StInstFetch;
         StInstFetch: state_d = StInstLoad;
         StInstLoad:  state_d = StIdle;
         StIdle:      state_d = StOpAddr;
         StOpAddr: begin
            if (opcode == OpHlt) begin
               state_d   = StHalted;
               retired_d = retired_q + CNT_WIDTH'(1);
            end else begin
               state_d = StOpFetch;
            end
         end
         StOpFetch:   state_d = StAluOp;
         StAluOp:     state_d = StStore;
         StStore: begin
            state_d   = StInstAddr;
            retired_d = retired_q + CNT_WIDTH'(1);
         end
         StHalted:    state_d = resume ? StInstAddr : StHalted;
         // Illegal encodings fall back to the start of a fetch.
         default:     state_d = StInstAddr;
      endcase
   end

   // Control strobe decode from registered state and live opcode/zero.
   always_comb begin
      sel    = 1'b0;
      rd     = 1'b0;
      ld_ir  = 1'b0;
      inc_pc = 1'b0;
      ld_pc  = 1'b0;
      ld_ac  = 1'b0;
      wr     = 1'b0;
      data_e = 1'b0;
      halt   = 1'b0;
      phase  = state_q[2:0];
      case (state_q)
         StInstAddr: sel = 1'b1;
         StInstFetch: begin
            sel = 1'b1;
            rd  = 1'b1;
         end
         StInstLoad, StIdle: begin
            sel   = 1'b1;
            rd    = 1'b1;
            ld_ir = 1'b1;
         end
         StOpAddr: begin
            inc_pc = 1'b1;
            halt   = (opcode == OpHlt);
         end
         StOpFetch: rd = aluop;
         StAluOp: begin
            rd     = aluop;
            inc_pc = (opcode == OpSkz) && zero;
            ld_pc  = (opcode == OpJmp);
            data_e = (opcode == OpSto);
         end
         StStore: begin
            rd     = aluop;
            inc_pc = (opcode == OpJmp);
            ld_pc  = (opcode == OpJmp);
            ld_ac  = aluop;
            wr     = (opcode == OpSto);
            data_e = (opcode == OpSto);
         end
         StHalted: begin
            halt  = 1'b1;
            phase = 3'd4;
         end
         default: phase = 3'd0;
      endcase
   end

   // State and retired-instruction counter registers.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q   <= StInstAddr;
         retired_q <= '0;
      end else begin
         state_q   <= state_d;
         retired_q <= retired_d;
      end
   end

endmodule

// File: tb/tb_ctrl_seq.sv
// Self-checking bench for ctrl_seq: a per-cycle expectation is queued as
// each cycle's stimulus is applied and compared against the DUT mid-cycle.
module tb_ctrl_seq;
   import risc_pkg::*;

   localparam int unsigned CW = 4;

   logic          clk = 1'b0;
   logic          rst_n;
   opcode_e       opcode;
   logic          zero;
   logic          resume;
   logic          sel, rd, ld_ir, inc_pc, ld_pc, ld_ac, wr, data_e, halt;
   logic [2:0]    phase;
   logic [CW-1:0] retired;

   ctrl_seq #(.CNT_WIDTH(CW)) dut (
      .clk     (clk),
      .rst_n   (rst_n),
      .opcode  (opcode),
      .zero    (zero),
      .resume  (resume),
      .sel     (sel),
      .rd      (rd),
      .ld_ir   (ld_ir),
      .inc_pc  (inc_pc),
      .ld_pc   (ld_pc),
      .ld_ac   (ld_ac),
      .wr      (wr),
      .data_e  (data_e),
      .halt    (halt),
      .phase   (phase),
      .retired (retired)
   );

   always #5 clk = ~clk;

   typedef struct packed {
      logic [8:0]    strb;  // {sel,rd,ld_ir,inc_pc,ld_pc,ld_ac,wr,data_e,halt}
      logic [2:0]    ph;
      logic [CW-1:0] ret;
   } exp_t;

   exp_t sb[$];
   int   total = 0;
   int   bad   = 0;

   // Bench model state: 0..7 run phases, 8 = halted.
   int            m_state;
   logic [CW-1:0] m_ret;

   task automatic check_val(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      total++;
      if (obs !== exp) begin
         bad++;
         $display("FAIL %s: got %0h want %0h", tag, obs, exp);
      end
   endtask

   function automatic logic [8:0] exp_strobes(int st, opcode_e op, logic z);
      logic s, r, li, ip, lp, la, w, de, h, alu;
      {s, r, li, ip, lp, la, w, de, h} = '0;
      alu = (op == OpAdd) || (op == OpAnd) || (op == OpXor) || (op == OpLda);
      case (st)
         0: s = 1'b1;
         1: begin s = 1'b1; r = 1'b1; end
         2, 3: begin s = 1'b1; r = 1'b1; li = 1'b1; end
         4: begin ip = 1'b1; h = (op == OpHlt); end
         5: r = alu;
         6: begin
            r  = alu;
            ip = (op == OpSkz) && z;
            lp = (op == OpJmp);
            de = (op == OpSto);
         end
         7: begin
            r  = alu;
            ip = (op == OpJmp);
            lp = (op == OpJmp);
            la = alu;
            w  = (op == OpSto);
            de = (op == OpSto);
         end
         default: h = 1'b1;
      endcase
      return {s, r, li, ip, lp, la, w, de, h};
   endfunction

   // Called just after a rising edge: apply inputs, queue expectation, advance model.
   task automatic cycle(input opcode_e op, input logic z, input logic res);
      exp_t e;
      int   nxt;
      opcode = op;
      zero   = z;
      resume = res;
      e.strb = exp_strobes(m_state, op, z);
      e.ph   = (m_state == 8) ? 3'd4 : 3'(m_state);
      e.ret  = m_ret;
      sb.push_back(e);
      if (m_state == 8) begin
         nxt = res ? 0 : 8;
      end else if (m_state == 4 && op == OpHlt) begin
         nxt   = 8;
         m_ret = m_ret + 1'b1;
      end else if (m_state == 7) begin
         nxt   = 0;
         m_ret = m_ret + 1'b1;
      end else begin
         nxt = m_state + 1;
      end
      @(posedge clk);
      #1;
      m_state = nxt;
   endtask

   task automatic run_instr(input opcode_e op, input logic z, input logic res);
      for (int i = 0; i < 8; i++) cycle(op, z, res);
   endtask

   // Compare queued expectations at the falling edge, away from state updates.
   initial begin
      exp_t e;
      forever begin
         @(negedge clk);
         if (sb.size() != 0) begin
            e = sb.pop_front();
            check_val($sformatf("strobes@ph%0d", e.ph),
                      {sel, rd, ld_ir, inc_pc, ld_pc, ld_ac, wr, data_e, halt}, e.strb);
            check_val("phase", phase, e.ph);
            check_val("retired", retired, e.ret);
         end
      end
   end

   initial begin
      rst_n   = 1'b0;
      opcode  = OpSto;
      zero    = 1'b0;
      resume  = 1'b0;
      m_state = 0;
      m_ret   = '0;
      repeat (2) @(posedge clk);
      #1;
      check_val("rst_strobes", {sel, rd, ld_ir, inc_pc, ld_pc, ld_ac, wr, data_e, halt},
                9'b1_0000_0000);
      check_val("rst_phase", phase, 0);
      check_val("rst_retired", retired, 0);
      rst_n = 1'b1;

      run_instr(OpAdd, 1'b0, 1'b0);
      run_instr(OpSkz, 1'b1, 1'b0);
      run_instr(OpSkz, 1'b0, 1'b0);
      run_instr(OpSto, 1'b1, 1'b0);
      run_instr(OpJmp, 1'b0, 1'b0);
      run_instr(OpAnd, 1'($urandom_range(0, 1)), 1'b0);
      run_instr(OpXor, 1'($urandom_range(0, 1)), 1'b0);
      run_instr(OpLda, 1'($urandom_range(0, 1)), 1'b0);
      // resume outside HALTED must be ignored
      run_instr(OpAdd, 1'b0, 1'b1);

      // HLT: phases 0..4, then hold in HALTED, then resume
      for (int i = 0; i < 5; i++) cycle(OpHlt, 1'b0, 1'b0);
      for (int i = 0; i < 10; i++) cycle(opcode_e'($urandom_range(0, 7)), 1'b1, 1'b0);
      cycle(OpHlt, 1'b0, 1'b1);
      check_val("resume_phase", phase, 0);

      // 16 instructions wrap the 4-bit counter
      for (int i = 0; i < 16; i++) run_instr(OpAdd, 1'b0, 1'b0);
      check_val("wrap_retired", retired, m_ret);

      // Reset in the middle of STORE with STO: wr must drop at once
      for (int i = 0; i < 7; i++) cycle(OpSto, 1'b0, 1'b0);
      @(negedge clk);
      check_val("sto_wr_high", wr, 1);
      rst_n = 1'b0;
      #1;
      check_val("rst_wr_drop", wr, 0);
      check_val("rst2_strobes", {sel, rd, ld_ir, inc_pc, ld_pc, ld_ac, wr, data_e, halt},
                9'b1_0000_0000);
      check_val("rst2_phase", phase, 0);
      check_val("rst2_retired", retired, 0);
      @(posedge clk);
      #1;
      rst_n   = 1'b1;
      m_state = 0;
      m_ret   = '0;
      run_instr(OpAdd, 1'b0, 1'b0);

      @(negedge clk);
      check_val("sb_drain", sb.size(), 0);
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
